zl_ts_null_mux: RTL and testbench
=================================

ZL_TS_NULL_MUX -- requirements
Module: zl_ts_null_mux

Interface
REQ-001 Parameter Idle_timeout, default 16, idle cycles at a packet boundary before a null packet is scheduled (range 1..255).
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 ts_in_data  input  8  user transport-stream byte.
REQ-005 ts_in_req  input  1  user byte valid; data held stable until acked.
REQ-006 ts_in_ack  output  1  user byte consumed; a transfer occurs when req and ack are both high.
REQ-007 data_out  output  8  byte to the DVB-S core data_in.
REQ-008 data_out_req  output  1  data_out valid.
REQ-009 data_out_ack  input  1  downstream accepted data_out.
REQ-010 sync_err  output  1  one-cycle pulse per byte discarded during resync.
REQ-011 null_pkt  output  1  one-cycle pulse when a null packet starts.

Function
REQ-012 The block SHALL emit only whole 188-byte packets, scheduling between the user stream and an internal null-packet generator at packet boundaries only.
REQ-013 FSM states: IDLE (boundary decision), PASS (user packet), NULL (generated packet).
REQ-014 IDLE: data_out_req=0; if ts_in_req=1 and ts_in_data=0x47 -> PASS next cycle, byte not consumed.
REQ-015 IDLE: if ts_in_req=1 and ts_in_data!=0x47 -> ts_in_ack=1 that cycle (byte discarded), sync_err=1, stay IDLE.
REQ-016 IDLE: idle counter increments each cycle ts_in_req=0; when it reaches Idle_timeout -> NULL, null_pkt=1; the counter clears on entry to IDLE and on any discarded byte.
REQ-017 Simultaneous valid 0x47 and timeout in one cycle: PASS SHALL win; no null_pkt pulse.
REQ-018 PASS: combinational pass-through, zero latency: data_out=ts_in_data, data_out_req=ts_in_req, ts_in_ack=data_out_ack.
REQ-019 PASS: byte counter 0..187 advances per transfer; transfer with count 187 -> IDLE, counter to 0; source stalls stall output, no nulls mid-packet.
REQ-020 NULL: data_out_req=1 every cycle; bytes 0..3 = 0x47,0x1F,0xFF,0x10; bytes 4..187 = 0xFF; ts_in_ack=0.
REQ-021 NULL: counter advances only on data_out_ack; transfer of byte 187 -> IDLE; NULL is not preemptible.
REQ-022 Counter arithmetic: 8-bit, never exceeds 187; no wrap beyond terminal value.
REQ-023 data_out SHALL equal 0x00 whenever data_out_req=0 outside PASS.

Reset
REQ-024 On rst_n low, asynchronously: state=IDLE, byte and idle counters=0, data_out_req=0, ts_in_ack=0, data_out=0x00, sync_err=0, null_pkt=0.
REQ-025 Reset mid-packet SHALL abandon the packet; after release the block restarts at a boundary.

Configuration
REQ-026 Macro ZL_TS_NULL_INSERT_EN defined: null insertion per REQ-016..021.
REQ-027 Macro undefined: NULL state and idle counter are removed; IDLE waits indefinitely for a 0x47; null_pkt tied 0.

Structure
REQ-028 Shared include zl_ts_defs.v SHALL hold TS constants: packet length 188, sync 0x47, null header bytes 0x1F,0xFF,0x10, stuffing 0xFF, FSM state encodings.
REQ-029 One sub-module, zl_ts_null_gen: byte-index to null-byte lookup, combinational.

Verification
REQ-030 Reset release, ts_in_req=0, data_out_ack=1, Idle_timeout=16 -> null_pkt at cycle 16; 188 bytes 47 1F FF 10 FF.. out on consecutive cycles.
REQ-031 User packet 47 00 01 .. held valid, data_out_ack=1 -> identical 188 bytes out with zero latency; no null_pkt.
REQ-032 Bytes 0x12,0x34 then 0x47 at boundary -> two sync_err pulses, two bytes discarded, then user packet passes.
REQ-033 Source drops req at byte 100 for 50 cycles -> output stalls, no null packet, packet resumes at byte 100.
REQ-034 data_out_ack toggling 1/0 during NULL -> every byte held until acked, exactly 188 transfers.
REQ-035 rst_n asserted at PASS byte 60 -> outputs per REQ-024 immediately; next valid 0x47 starts a fresh packet.

Source files
------------

// File: rtl/zl_ts_null_mux_pkg.sv
// Transport-stream constants shared by the null-packet mux and its generator:
// packet geometry, sync/null header bytes and FSM state encodings.
package zl_ts_null_mux_pkg;

    localparam int unsigned TS_BYTE_W  = 8;
    localparam int unsigned TS_PKT_LEN = 188;

    localparam logic [TS_BYTE_W-1:0] TS_SYNC     = 8'h47;
    localparam logic [TS_BYTE_W-1:0] TS_NULL_H1  = 8'h1F;
    localparam logic [TS_BYTE_W-1:0] TS_NULL_H2  = 8'hFF;
    localparam logic [TS_BYTE_W-1:0] TS_NULL_H3  = 8'h10;
    localparam logic [TS_BYTE_W-1:0] TS_STUFF    = 8'hFF;
    localparam logic [TS_BYTE_W-1:0] TS_LAST_IDX = 8'(TS_PKT_LEN - 1);

    localparam int unsigned ST_W = 2;
    localparam logic [ST_W-1:0] ST_IDLE = 2'd0;
    localparam logic [ST_W-1:0] ST_PASS = 2'd1;
    localparam logic [ST_W-1:0] ST_NULL = 2'd2;

endpackage

// File: rtl/zl_ts_null_mux_null_gen.sv
// Null-packet byte lookup: maps a byte index within the packet to the
// corresponding byte of a null TS packet (header 47 1F FF 10, then stuffing).
module zl_ts_null_gen
    import zl_ts_null_mux_pkg::*;
(
    input  logic [TS_BYTE_W-1:0] idx_i,
    output logic [TS_BYTE_W-1:0] byte_o
);

    // Header bytes by index, stuffing everywhere else
    always_comb begin
        byte_o = TS_STUFF;
        case (idx_i)
            8'd0:    byte_o = TS_SYNC;
            8'd1:    byte_o = TS_NULL_H1;
            8'd2:    byte_o = TS_NULL_H2;
            8'd3:    byte_o = TS_NULL_H3;
            default: byte_o = TS_STUFF;
        endcase
    end

endmodule

// File: rtl/zl_ts_null_mux.sv
// TS null-packet mux: forwards whole 188-byte user packets to the DVB-S core
// and, when ZL_TS_NULL_INSERT_EN is defined, fills idle gaps at packet
// boundaries with generated null packets. Without the macro the block only
// resynchronises on 0x47 and passes user packets through.
// The data path is a zero-latency req/ack pass-through; only the FSM,
// counters and the two status pulses are registered.
module zl_ts_null_mux
    import zl_ts_null_mux_pkg::*;
#(
    parameter int unsigned Idle_timeout = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [TS_BYTE_W-1:0] ts_in_data,
    input  logic                 ts_in_req,
    output logic                 ts_in_ack,
    output logic [TS_BYTE_W-1:0] data_out,
    output logic                 data_out_req,
    input  logic                 data_out_ack,
    output logic                 sync_err,
    output logic                 null_pkt
);

    if (Idle_timeout < 1 || Idle_timeout > 255) begin : g_bad_timeout
        $error("zl_ts_null_mux: Idle_timeout must be in 1..255");
    end

    logic [ST_W-1:0]      state_q, state_d;
    logic [TS_BYTE_W-1:0] byte_q, byte_d;
    logic                 sync_err_q, sync_err_d;
    logic                 null_pkt_q, null_pkt_d;

`ifdef ZL_TS_NULL_INSERT_EN
    localparam logic [TS_BYTE_W-1:0] IDLE_LAST = 8'(Idle_timeout - 1);

    logic [TS_BYTE_W-1:0] idle_q, idle_d;
    logic [TS_BYTE_W-1:0] null_byte;

    zl_ts_null_gen u_null_gen (
        .idx_i  (byte_q),
        .byte_o (null_byte)
    );
`endif

    // State, counters and status pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            byte_q     <= '0;
            sync_err_q <= 1'b0;
            null_pkt_q <= 1'b0;
`ifdef ZL_TS_NULL_INSERT_EN
            idle_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            byte_q     <= byte_d;
            sync_err_q <= sync_err_d;
            null_pkt_q <= null_pkt_d;
`ifdef ZL_TS_NULL_INSERT_EN
            idle_q     <= idle_d;
`endif
        end
    end

    // Boundary scheduling, packet byte counting and the output data path
    always_comb begin
        state_d      = state_q;
        byte_d       = byte_q;
        sync_err_d   = 1'b0;
        null_pkt_d   = 1'b0;
        ts_in_ack    = 1'b0;
        data_out     = '0;
        data_out_req = 1'b0;
`ifdef ZL_TS_NULL_INSERT_EN
        idle_d       = idle_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (ts_in_req) begin
                    if (ts_in_data == TS_SYNC) begin
                        // Sync byte stays on the bus; PASS forwards it
                        state_d = ST_PASS;
                        byte_d  = '0;
`ifdef ZL_TS_NULL_INSERT_EN
                        idle_d  = '0;
`endif
                    end else begin
                        // Discard: the async reset keeps the source from being acked
                        ts_in_ack  = rst_n;
                        sync_err_d = 1'b1;
`ifdef ZL_TS_NULL_INSERT_EN
                        idle_d     = '0;
`endif
                    end
                end
`ifdef ZL_TS_NULL_INSERT_EN
                else if (idle_q == IDLE_LAST) begin
                    state_d    = ST_NULL;
                    byte_d     = '0;
                    idle_d     = '0;
                    null_pkt_d = 1'b1;
                end else begin
                    idle_d = idle_q + 8'd1;
                end
`endif
            end

            ST_PASS: begin
                data_out     = ts_in_data;
                data_out_req = ts_in_req;
                ts_in_ack    = data_out_ack;
                if (ts_in_req && data_out_ack) begin
                    if (byte_q == TS_LAST_IDX) begin
                        state_d = ST_IDLE;
                        byte_d  = '0;
                    end else begin
                        byte_d = byte_q + 8'd1;
                    end
                end
            end

`ifdef ZL_TS_NULL_INSERT_EN
            ST_NULL: begin
                data_out     = null_byte;
                data_out_req = 1'b1;
                if (data_out_ack) begin
                    if (byte_q == TS_LAST_IDX) begin
                        state_d = ST_IDLE;
                        byte_d  = '0;
                    end else begin
                        byte_d = byte_q + 8'd1;
                    end
                end
            end
`endif

            default: begin
                state_d = ST_IDLE;
                byte_d  = '0;
            end
        endcase
    end

    assign sync_err = sync_err_q;
    assign null_pkt = null_pkt_q;

endmodule

// File: tb/tb_zl_ts_null_mux.sv
// Self-checking bench for zl_ts_null_mux (Idle_timeout = 16). Expected output
// bytes come from a queue the bench fills from its own packet rules; a compare
// process checks every output transfer, the hold-until-ack rule and counts the
// status pulses. Works with or without ZL_TS_NULL_INSERT_EN.
module tb_zl_ts_null_mux;

    localparam int PKT  = 188;
    localparam int TOUT = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] ts_in_data = 8'h00;
    logic       ts_in_req = 1'b0;
    logic       ts_in_ack;
    logic [7:0] data_out;
    logic       data_out_req;
    logic       data_out_ack = 1'b1;
    logic       sync_err;
    logic       null_pkt;

    int total = 0;
    int bad   = 0;

    logic [7:0] exp_q[$];
    logic [7:0] src[$];
    logic [7:0] out_log[256];
    int  cyc, null_cnt, sync_cnt, null_cyc, xfer_cnt, last_xfer_cyc;
    bit  ack_toggle = 1'b0;
    int  consumed;

    zl_ts_null_mux #(.Idle_timeout(TOUT)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ts_in_data   (ts_in_data),
        .ts_in_req    (ts_in_req),
        .ts_in_ack    (ts_in_ack),
        .data_out     (data_out),
        .data_out_req (data_out_req),
        .data_out_ack (data_out_ack),
        .sync_err     (sync_err),
        .null_pkt     (null_pkt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got 0x%0h required 0x%0h", nm, act, req);
        end
    endtask

    task automatic fail(input string nm, input int act, input int req);
        total++;
        bad++;
        $display("FAIL %s: got %0d required %0d", nm, act, req);
    endtask

    // Null packet content: 4-byte header then stuffing
    function automatic logic [7:0] null_model(input int i);
        logic [7:0] hdr[4];
        hdr = '{8'h47, 8'h1F, 8'hFF, 8'h10};
        return (i < 4) ? hdr[i] : 8'hFF;
    endfunction

    // User packet: sync byte then an incrementing payload starting at 'start'
    function automatic logic [7:0] user_byte(input int start, input int i);
        return (i == 0) ? 8'h47 : 8'((start + i - 1) % 256);
    endfunction

    task automatic push_user(input int start, input int nexp);
        for (int i = 0; i < PKT; i++) src.push_back(user_byte(start, i));
        for (int i = 0; i < nexp; i++) exp_q.push_back(user_byte(start, i));
    endtask

    task automatic compare_loop();
        bit         hold_pend = 1'b0;
        logic [7:0] hold_dat = 8'h00;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                cyc = 0; null_cnt = 0; sync_cnt = 0; null_cyc = -1;
                xfer_cnt = 0; last_xfer_cyc = -1; hold_pend = 1'b0;
            end else begin
                if (hold_pend) begin
                    chk("hold_req", int'(data_out_req), 1);
                    chk("hold_data", int'(data_out), int'(hold_dat));
                end
                if (null_pkt) begin
                    null_cnt++;
                    if (null_cyc < 0) null_cyc = cyc;
                end
                if (sync_err) sync_cnt++;
                if (data_out_req && data_out_ack) begin
                    if (exp_q.size() == 0) fail("extra_xfer", int'(data_out), -1);
                    else chk("xfer_byte", int'(data_out), int'(exp_q.pop_front()));
                    if (xfer_cnt < 256) out_log[xfer_cnt] = data_out;
                    xfer_cnt++;
                    last_xfer_cyc = cyc;
                end
                hold_pend = data_out_req && !data_out_ack;
                hold_dat  = data_out;
                cyc++;
            end
        end
    endtask

    task automatic ack_driver();
        forever begin
            @(posedge clk); #1;
            if (ack_toggle) data_out_ack = ~data_out_ack;
        end
    endtask

    // Ends one time unit after a posedge, which is the start of cycle 0
    task automatic do_reset();
        ack_toggle = 1'b0;
        ts_in_req = 1'b0; ts_in_data = 8'h00; data_out_ack = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        exp_q.delete();
        src.delete();
        data_out_ack = 1'b1;
        rst_n = 1'b1;
    endtask

    // Offers src bytes with req/ack; optional stall and mid-packet reset
    task automatic drive(input int stall_at, input int stall_len, input int rst_at,
                         output int n_acked);
        int idx = 0;
        int guard = 0;
        bit stalled = 1'b0;
        bit acc;
        while (idx < src.size() && guard < 3000) begin
            if (idx == stall_at && !stalled) begin
                stalled = 1'b1;
                ts_in_req = 1'b0; ts_in_data = 8'h00;
                repeat (stall_len) begin
                    @(negedge clk);
                    chk("stall_req", int'(data_out_req), 0);
                    @(posedge clk); #1;
                end
            end
            ts_in_req = 1'b1; ts_in_data = src[idx];
            if (idx == rst_at) begin
                #2 rst_n = 1'b0;
                #1;
                chk("rst_mid_req", int'(data_out_req), 0);
                chk("rst_mid_ack", int'(ts_in_ack), 0);
                chk("rst_mid_data", int'(data_out), 0);
                chk("rst_mid_null", int'(null_pkt), 0);
                chk("rst_mid_sync", int'(sync_err), 0);
                break;
            end
            @(negedge clk);
            acc = ts_in_ack;
            @(posedge clk); #1;
            if (acc) idx++;
            guard++;
        end
        if (guard >= 3000) fail("drive_timeout", idx, src.size());
        ts_in_req = 1'b0; ts_in_data = 8'h00;
        n_acked = idx;
    endtask

    task automatic wait_drain(input string nm, input int limit);
        int n = 0;
        while (exp_q.size() != 0 && n < limit) begin
            @(posedge clk); #1;
            n++;
        end
        if (exp_q.size() != 0) fail(nm, exp_q.size(), 0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        fork
            compare_loop();
            ack_driver();
            begin
                #500000;
                $display("FAIL watchdog: got timeout required finish");
                $fatal(1, "watchdog");
            end
        join_none

        // Reset values, with a non-sync byte offered during reset
        ts_in_req = 1'b1; ts_in_data = 8'h12;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ack", int'(ts_in_ack), 0);
        chk("rst_req", int'(data_out_req), 0);
        chk("rst_data", int'(data_out), 0);
        chk("rst_sync", int'(sync_err), 0);
        chk("rst_null", int'(null_pkt), 0);
        do_reset();

        // Idle source: null packet after the timeout, or nothing at all
`ifdef ZL_TS_NULL_INSERT_EN
        for (int i = 0; i < PKT; i++) exp_q.push_back(null_model(i));
        wait_drain("t1_drain", 400);
        chk("t1_null_cyc", null_cyc, 16);
        chk("t1_null_cnt", null_cnt, 1);
        chk("t1_xfers", xfer_cnt, PKT);
        chk("t1_last_cyc", last_xfer_cyc, 203);
        chk("t1_b0", int'(out_log[0]), 'h47);
        chk("t1_b1", int'(out_log[1]), 'h1F);
        chk("t1_b2", int'(out_log[2]), 'hFF);
        chk("t1_b3", int'(out_log[3]), 'h10);
        chk("t1_b4", int'(out_log[4]), 'hFF);
        chk("t1_b187", int'(out_log[187]), 'hFF);
`else
        repeat (300) @(posedge clk);
        #1;
        chk("t1_null_cnt", null_cnt, 0);
        chk("t1_xfers", xfer_cnt, 0);
        chk("t1_idle_data", int'(data_out), 0);
`endif
        do_reset();

        // Plain user packet, zero latency
        push_user(0, PKT);
        drive(-1, 0, -1, consumed);
        wait_drain("t2_drain", 100);
        chk("t2_consumed", consumed, PKT);
        chk("t2_null_cnt", null_cnt, 0);
        chk("t2_sync_cnt", sync_cnt, 0);
        chk("t2_xfers", xfer_cnt, PKT);
        chk("t2_last_cyc", last_xfer_cyc, 188);
        chk("t2_b0", int'(out_log[0]), 'h47);
        chk("t2_b2", int'(out_log[2]), 'h01);
        chk("t2_b187", int'(out_log[187]), 'hBA);
        do_reset();

        // Two garbage bytes before the sync byte
        src.push_back(8'h12);
        src.push_back(8'h34);
        push_user('h80, PKT);
        drive(-1, 0, -1, consumed);
        wait_drain("t3_drain", 100);
        chk("t3_consumed", consumed, PKT + 2);
        chk("t3_sync_cnt", sync_cnt, 2);
        chk("t3_null_cnt", null_cnt, 0);
        chk("t3_xfers", xfer_cnt, PKT);
        chk("t3_last_cyc", last_xfer_cyc, 190);
        do_reset();

        // Source stall of 50 cycles before byte 100
        push_user('h10, PKT);
        drive(100, 50, -1, consumed);
        wait_drain("t4_drain", 100);
        chk("t4_null_cnt", null_cnt, 0);
        chk("t4_xfers", xfer_cnt, PKT);
        chk("t4_b100", int'(out_log[100]), 'h73);
        chk("t4_last_cyc", last_xfer_cyc, 238);
        do_reset();

`ifdef ZL_TS_NULL_INSERT_EN
        // Null packet under a toggling downstream ack
        ack_toggle = 1'b1;
        for (int i = 0; i < PKT; i++) exp_q.push_back(null_model(i));
        wait_drain("t5_drain", 800);
        ack_toggle = 1'b0;
        chk("t5_null_cnt", null_cnt, 1);
        chk("t5_xfers", xfer_cnt, PKT);
        chk("t5_b3", int'(out_log[3]), 'h10);
        do_reset();
`endif

        // Reset while byte 60 of a user packet is on the bus
        push_user('h20, 60);
        drive(-1, 0, 60, consumed);
        chk("t6_consumed", consumed, 60);
        chk("t6_xfers", xfer_cnt, 60);
        chk("t6_left", exp_q.size(), 0);
        do_reset();
        push_user('h60, PKT);
        drive(-1, 0, -1, consumed);
        wait_drain("t6_drain", 100);
        chk("t6_new_xfers", xfer_cnt, PKT);
        chk("t6_new_b1", int'(out_log[1]), 'h60);
        chk("t6_new_null", null_cnt, 0);
        do_reset();

        // Sync byte arrives in the same cycle the idle timeout would fire
        repeat (TOUT - 1) @(posedge clk);
        #1;
        chk("t7_idle_req", int'(data_out_req), 0);
        chk("t7_idle_data", int'(data_out), 0);
        push_user('h30, PKT);
        drive(-1, 0, -1, consumed);
        wait_drain("t7_drain", 100);
        chk("t7_null_cnt", null_cnt, 0);
        chk("t7_xfers", xfer_cnt, PKT);
        chk("t7_last_cyc", last_xfer_cyc, 203);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
